// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state type for the mux_arb4 arbiter
package mux_arb_pkg;

  localparam int N_REQ        = 4;
  localparam int SEL_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick over four candidates
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Walk offsets from farthest to nearest so the slot right after ptr wins last.
  always_comb begin : pick
    logic [SEL_W-1:0] cand;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb4.sv
// rtl/mux_arb4.sv - 4-way round-robin arbiter driving a 4:1 bit mux
// Optional hold limit with preemption: MUX_ARB_HOLD_LIMIT_EN.
module mux_arb4
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] d,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             o,
  output logic             preempt
);

  arb_state_t       state, state_n;
  logic [SEL_W-1:0] owner, owner_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] own_oh;
  logic [N_REQ-1:0] pick_mask;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic              hold_sat;
  logic              preempt_r, preempt_n;
  assign hold_sat = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign preempt  = preempt_r;
`else
  assign preempt  = 1'b0;
`endif

  assign own_oh    = N_REQ'(1) << owner;
  // While granted, the current owner is never a candidate for the next pick.
  assign pick_mask = (state == ARB_GRANT) ? (req & ~own_oh) : req;

  rr_pick4 u_pick (
    .ptr   (ptr),
    .mask  (pick_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    hold_n    = hold_cnt;
    preempt_n = 1'b0;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_n = ARB_GRANT;
          owner_n = pick_idx;
          ptr_n   = pick_idx;
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_n  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!req[owner]) begin
          if (pick_found) begin
            owner_n = pick_idx;
            ptr_n   = pick_idx;
          end else begin
            state_n = ARB_IDLE;
          end
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_n = '0;
        end else if (hold_sat && pick_found) begin
          owner_n   = pick_idx;
          ptr_n     = pick_idx;
          hold_n    = '0;
          preempt_n = 1'b1;
        end else if (!hold_sat) begin
          hold_n = hold_cnt + 1'b1;
`endif
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr   <= SEL_W'(N_REQ - 1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt  <= '0;
      preempt_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt  <= hold_n;
      preempt_r <= preempt_n;
`endif
    end
  end

  assign valid = (state == ARB_GRANT);
  assign sel   = owner;
  assign gnt   = valid ? own_oh : '0;
  assign o     = valid & d[sel];

endmodule

// File: tb/tb_mux_arb4.sv
// tb/tb_mux_arb4.sv - table-driven scoreboard bench for mux_arb4
module tb_mux_arb4;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       o;
    logic       preempt;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       o;
    logic       preempt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       o;
  logic       preempt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  vec_t vecs[18];

  mux_arb4 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d       (d),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .o       (o),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input int idx, input logic r, input logic [3:0] rq, input logic [3:0] dd,
                      input logic [3:0] eg, input logic [1:0] es, input logic ev,
                      input logic eo, input logic ep);
    exp_t e;
    rst_n = r;
    req   = rq;
    d     = dd;
    e.gnt = eg; e.sel = es; e.valid = ev; e.o = eo; e.preempt = ep;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", idx, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check("gnt", idx, {4'd0, gnt}, {4'd0, e.gnt});
      check("sel", idx, {6'd0, sel}, {6'd0, e.sel});
      check("valid", idx, {7'd0, valid}, {7'd0, e.valid});
      check("o", idx, {7'd0, o}, {7'd0, e.o});
      check("preempt", idx, {7'd0, preempt}, {7'd0, e.preempt});
    end
  endtask

  initial begin
    //         rst   req      d        gnt      sel    v     o     pre
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 4'hF, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'hF, 4'hF, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'hF, 4'h5, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'hE, 4'h5, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'hD, 4'h5, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'hB, 4'h5, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'h7, 4'h5, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, 4'h5, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'h4, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 4'h4, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'h2, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 4'hB, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'h9, 4'h2, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'h2, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'h2, 4'h2, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 4'h6, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 4'h0, 4'hF, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 4'h0;
    d     = 4'h0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      step(i, vecs[i].rst_n, vecs[i].req, vecs[i].d, vecs[i].gnt, vecs[i].sel,
           vecs[i].valid, vecs[i].o, vecs[i].preempt);
    end

`ifdef MUX_ARB_HOLD_LIMIT_EN
    // Two sources held: each keeps the mux for 4 cycles, then is preempted.
    step(100, 1'b0, 4'h0, 4'h1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      logic own1;
      own1 = ((c / 4) % 2) == 1;
      step(200 + c, 1'b1, 4'h3, 4'h1, own1 ? 4'b0010 : 4'b0001, own1 ? 2'd1 : 2'd0,
           1'b1, !own1, (c % 4 == 0) && (c > 0));
    end
    // Lone requester is never preempted.
    for (int c = 0; c < 20; c++) begin
      step(300 + c, 1'b1, 4'h4, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    end
`endif

    if (exp_q.size() != 0) begin
      check("scoreboard_leftover", 0, 8'(exp_q.size()), 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
